// File: rtl/lane_pkg.sv
// Shared types and constants for the lane loader: FSM state encoding and lane geometry.
package lane_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NUM_LANES = 8;
  localparam int IDX_W     = 3;

endpackage

// File: rtl/lane_reg_bank.sv
// Eight registered lanes written one at a time through a one-hot decode, with synchronous clear.
module lane_reg_bank
  import lane_pkg::*;
#(
  parameter int WIREWIDTH = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_clear,
  input  logic                                 i_wr_en,
  input  logic [IDX_W-1:0]                     i_wr_idx,
  input  logic [WIREWIDTH:0]                   i_wr_data,
  output logic [NUM_LANES-1:0][WIREWIDTH:0]    o_lanes
);

  logic [NUM_LANES-1:0]              w_wr_onehot;
  logic [NUM_LANES-1:0][WIREWIDTH:0] r_lanes;

  always_comb begin
    w_wr_onehot = '0;
    if (i_wr_en) begin
      w_wr_onehot[i_wr_idx] = 1'b1;
    end
  end

  // Clear beats a write; the loader never requests both in the same cycle anyway.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_lanes <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_wr_onehot[i]) begin
          r_lanes[i] <= i_wr_data;
        end
      end
    end
  end

  assign o_lanes = r_lanes;

endmodule

// File: rtl/lane_loader.sv
// Serial-to-parallel loader feeding the 8-connector box: fills d0..d7, holds until acked.
// Optional GUI schematic hooks are compiled in with LANE_LOADER_SCHEMATIC_EN.
module lane_loader
  import lane_pkg::*;
#(
  parameter int WIREWIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIREWIDTH:0]   in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WIREWIDTH:0]   d0,
  output logic [WIREWIDTH:0]   d1,
  output logic [WIREWIDTH:0]   d2,
  output logic [WIREWIDTH:0]   d3,
  output logic [WIREWIDTH:0]   d4,
  output logic [WIREWIDTH:0]   d5,
  output logic [WIREWIDTH:0]   d6,
  output logic [WIREWIDTH:0]   d7,
  output logic [3:0]           fill_count,
  output logic                 frame_valid,
  input  logic                 out_ack,
  output logic                 s
);

  state_t                            r_state;
  state_t                            w_next_state;
  logic [IDX_W-1:0]                  r_idx;
  logic [3:0]                        r_fill_count;
  logic                              r_s;
  logic                              w_accept;
  logic                              w_frame_end;
  logic                              w_ack;
  logic [NUM_LANES-1:0][WIREWIDTH:0] w_lanes;

  assign w_accept    = in_valid && (r_state == FILL);
  assign w_frame_end = w_accept && ((r_idx == 3'd7) || in_last);
  assign w_ack       = out_ack && (r_state == HOLD);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL:    if (w_frame_end) w_next_state = HOLD;
      HOLD:    if (out_ack)     w_next_state = FILL;
      default: w_next_state = FILL;
    endcase
  end

  // idx wraps to 0 after lane 7, but that edge always enters HOLD and the ack resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_idx        <= '0;
      r_fill_count <= '0;
      r_s          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_idx        <= r_idx + 3'd1;
        r_fill_count <= {1'b0, r_idx} + 4'd1;
      end
      if (w_ack) begin
        r_idx        <= '0;
        r_fill_count <= '0;
        r_s          <= ~r_s;
      end
    end
  end

  lane_reg_bank #(
    .WIREWIDTH (WIREWIDTH)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_ack),
    .i_wr_en   (w_accept),
    .i_wr_idx  (r_idx),
    .i_wr_data (in_data),
    .o_lanes   (w_lanes)
  );

  assign in_ready    = (r_state == FILL);
  assign frame_valid = (r_state == HOLD);
  assign fill_count  = r_fill_count;
  assign s           = r_s;
  assign d0 = w_lanes[0];
  assign d1 = w_lanes[1];
  assign d2 = w_lanes[2];
  assign d3 = w_lanes[3];
  assign d4 = w_lanes[4];
  assign d5 = w_lanes[5];
  assign d6 = w_lanes[6];
  assign d7 = w_lanes[7];

`ifdef LANE_LOADER_SCHEMATIC_EN
  task automatic draw_bbox(input int w, input int h);
    $display("schematic bbox %0d x %0d", w, h);
  endtask

  task automatic draw_rect(input int x0, input int y0, input int x1, input int y1);
    $display("schematic rect %0d,%0d to %0d,%0d", x0, y0, x1, y1);
  endtask

  task automatic draw_connector(input string name, input int x, input int y);
    $display("schematic connector %s at %0d,%0d", name, x, y);
  endtask

  initial begin
    draw_bbox(140, 80);
    draw_rect(10, 10, 130, 70);
    draw_connector("in_data", 0, 40);
    for (int i = 0; i < NUM_LANES; i++) begin
      draw_connector($sformatf("d%0d", i), 140, 10 + i * 8);
    end
    draw_connector("s", 70, 80);
  end
`else
  // Synthesis builds carry no GUI hooks.
`endif

endmodule

// File: tb/tb_lane_loader.sv
// Directed self-checking bench for lane_loader with 8-bit words.
module tb_lane_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [3:0] fill_count;
  logic       frame_valid;
  logic       out_ack;
  logic       s;

  logic [7:0] lanes [8];
  int testsRun    = 0;
  int testsFailed = 0;

  assign lanes[0] = d0;
  assign lanes[1] = d1;
  assign lanes[2] = d2;
  assign lanes[3] = d3;
  assign lanes[4] = d4;
  assign lanes[5] = d5;
  assign lanes[6] = d6;
  assign lanes[7] = d7;

  always #5 clk = ~clk;

  lane_loader #(.WIREWIDTH(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .d6          (d6),
    .d7          (d7),
    .fill_count  (fill_count),
    .frame_valid (frame_valid),
    .out_ack     (out_ack),
    .s           (s)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [7:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulseAck();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (lanes[i] !== 8'h00) begin
        testsFailed++;
        $display("[TB] FAIL reset_lane%0d: got %h expected 00", i, lanes[i]);
      end
    end
    testsRun++;
    if ({fill_count, frame_valid, s, in_ready} !== 7'b0000_001) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: fill=%0d fv=%b s=%b rdy=%b expected 0 0 0 1",
               fill_count, frame_valid, s, in_ready);
    end
    sendWord(8'h71, 1'b0);
    sendWord(8'h72, 1'b0);
    sendWord(8'h73, 1'b0);
    testsRun++;
    if (fill_count !== 4'd3 || d2 !== 8'h73) begin
      testsFailed++;
      $display("[TB] FAIL prereset_fill: fill=%0d d2=%h expected 3 73", fill_count, d2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    testsRun++;
    if ({d0, d1, d2} !== 24'h0 || fill_count !== 4'd0 || s !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_midframe: d0..2=%h fill=%0d s=%b rdy=%b expected 0 0 0 1",
               {d0, d1, d2}, fill_count, s, in_ready);
    end
  endtask

  task automatic test_full_frame();
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (frame_valid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL full_early_fv word%0d: got %b expected 0", i, frame_valid);
      end
      in_data = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if (lanes[i] !== 8'h10 + 8'(i)) begin
        testsFailed++;
        $display("[TB] FAIL full_lane%0d: got %h expected %h", i, lanes[i], 8'h10 + 8'(i));
      end
    end
    testsRun++;
    if (frame_valid !== 1'b1 || fill_count !== 4'd8 || in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_ctrl: fv=%b fill=%0d rdy=%b expected 1 8 0",
               frame_valid, fill_count, in_ready);
    end
  endtask

  task automatic test_ack_hold();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    repeat (5) tick();
    testsRun++;
    if (d0 !== 8'h10 || d7 !== 8'h17 || fill_count !== 4'd8 || frame_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hold_stable: d0=%h d7=%h fill=%0d fv=%b expected 10 17 8 1",
               d0, d7, fill_count, frame_valid);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    pulseAck();
    testsRun++;
    if ({d0, d7} !== 16'h0 || fill_count !== 4'd0 || s !== 1'b1 ||
        in_ready !== 1'b1 || frame_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ack_release: d0=%h d7=%h fill=%0d s=%b rdy=%b fv=%b expected 0 0 0 1 1 0",
               d0, d7, fill_count, s, in_ready, frame_valid);
    end
  endtask

  task automatic test_short_frame();
    sendWord(8'hA1, 1'b0);
    sendWord(8'hA2, 1'b0);
    sendWord(8'hA3, 1'b1);
    testsRun++;
    if (fill_count !== 4'd3 || frame_valid !== 1'b1 || {d0, d1, d2} !== 24'hA1A2A3) begin
      testsFailed++;
      $display("[TB] FAIL short_frame: fill=%0d fv=%b d0..2=%h expected 3 1 a1a2a3",
               fill_count, frame_valid, {d0, d1, d2});
    end
    testsRun++;
    if ({d3, d4, d5, d6, d7} !== 40'h0) begin
      testsFailed++;
      $display("[TB] FAIL short_unwritten: d3..7=%h expected 0", {d3, d4, d5, d6, d7});
    end
    pulseAck();
    testsRun++;
    if (s !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL short_ack: s=%b rdy=%b expected 0 1", s, in_ready);
    end
  endtask

  task automatic test_stray_ack();
    sendWord(8'h31, 1'b0);
    sendWord(8'h32, 1'b0);
    pulseAck();
    testsRun++;
    if (fill_count !== 4'd2 || in_ready !== 1'b1 || s !== 1'b0 || d0 !== 8'h31 || d1 !== 8'h32) begin
      testsFailed++;
      $display("[TB] FAIL stray_ack: fill=%0d rdy=%b s=%b d0=%h d1=%h expected 2 1 0 31 32",
               fill_count, in_ready, s, d0, d1);
    end
    for (int i = 3; i <= 8; i++) begin
      sendWord(8'h30 + 8'(i), (i == 8));
    end
    testsRun++;
    if (fill_count !== 4'd8 || frame_valid !== 1'b1 || d7 !== 8'h38 || d2 !== 8'h33) begin
      testsFailed++;
      $display("[TB] FAIL last_on_eighth: fill=%0d fv=%b d2=%h d7=%h expected 8 1 33 38",
               fill_count, frame_valid, d2, d7);
    end
    tick();
    testsRun++;
    if (fill_count !== 4'd8 || frame_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_hold: fill=%0d fv=%b expected 8 1", fill_count, frame_valid);
    end
    pulseAck();
    testsRun++;
    if (frame_valid !== 1'b0 || in_ready !== 1'b1 || fill_count !== 4'd0 || s !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL eighth_ack: fv=%b rdy=%b fill=%0d s=%b expected 0 1 0 1",
               frame_valid, in_ready, fill_count, s);
    end
  endtask

  task automatic test_stall();
    logic [7:0] pattern [4];
    logic       validPat [4];
    pattern  = '{8'h51, 8'h99, 8'h52, 8'h98};
    validPat = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      in_valid = validPat[i];
      in_data  = pattern[i];
      tick();
      testsRun++;
      if (fill_count !== 4'((i / 2) + 1)) begin
        testsFailed++;
        $display("[TB] FAIL stall_fill step%0d: got %0d expected %0d", i, fill_count, (i / 2) + 1);
      end
    end
    in_valid = 1'b0;
    testsRun++;
    if (d0 !== 8'h51 || d1 !== 8'h52 || d2 !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL stall_lanes: d0=%h d1=%h d2=%h expected 51 52 00", d0, d1, d2);
    end
    sendWord(8'h53, 1'b1);
    testsRun++;
    if (frame_valid !== 1'b1 || fill_count !== 4'd3 || d2 !== 8'h53) begin
      testsFailed++;
      $display("[TB] FAIL stall_end: fv=%b fill=%0d d2=%h expected 1 3 53", frame_valid, fill_count, d2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    testsRun++;
    if (frame_valid !== 1'b0 || s !== 1'b0 || fill_count !== 4'd0 || d0 !== 8'h00 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_midhold: fv=%b s=%b fill=%0d d0=%h rdy=%b expected 0 0 0 00 1",
               frame_valid, s, fill_count, d0, in_ready);
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    out_ack  = 1'b0;
    #2;
    test_reset();
    test_full_frame();
    test_ack_hold();
    test_short_frame();
    test_stray_ack();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
